// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared ALU opcode encodings and the multi-cycle unit's FSM state type
package alu_muldiv_pkg;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_MUL = 4'h8;
    localparam logic [3:0] ALU_DIV = 4'h9;
    localparam logic [3:0] ALU_MOD = 4'hA;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_muldiv_step.sv
// alu_muldiv_step: one unsigned radix-2 step, MSB-first shift-add multiply or restoring divide
module alu_muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opr,
    input  logic [WIDTH-1:0] bq,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] opr_n
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign rem_sh = {acc, opr[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, bq};
    // diff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
    assign acc_n  = div ? (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0])
                        : (acc << 1) + (opr[WIDTH-1] ? bq : '0);
    assign opr_n  = {opr[WIDTH-2:0], div & ~diff[WIDTH]};
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle unsigned MUL/DIV/MOD unit with valid/ready handshakes
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             err
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_n;
    logic [3:0]       op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opr;
    logic [WIDTH-1:0] bq;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] opr_n;
    logic [CW-1:0]    cnt;
    logic             is_mul;
    logic             is_div;
    logic             is_mod;
    logic             go_busy;
    logic             last;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign is_mul    = ctrl == ALU_MUL;
    assign is_div    = ctrl == ALU_DIV;
    assign is_mod    = ctrl == ALU_MOD;
    // divide by zero and unknown opcodes resolve immediately without iterating
    assign go_busy   = is_mul || ((is_div || is_mod) && b != '0);
    assign last      = cnt == CW'(WIDTH - 1);

    alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div   (op != ALU_MUL),
        .acc   (acc),
        .opr   (opr),
        .bq    (bq),
        .acc_n (acc_n),
        .opr_n (opr_n)
    );

    always_comb begin
        state_n = state == IDLE ? (in_valid ? (go_busy ? BUSY : DONE) : IDLE)
                : state == BUSY ? (last ? DONE : BUSY)
                : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op  <= ALU_ADD;
            acc <= '0;
            opr <= '0;
            bq  <= '0;
            cnt <= '0;
            y   <= '0;
            err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            op  <= ctrl;
            acc <= '0;
            opr <= a;
            bq  <= b;
            cnt <= '0;
            if (!go_busy) begin
                y   <= is_div ? '1 : is_mod ? a : '0;
                err <= 1'b1;
            end
        end else if (state == BUSY) begin
            acc <= acc_n;
            opr <= opr_n;
            cnt <= cnt + CW'(1);
            // quotient accumulates in opr, product and remainder in acc
            if (last) begin
                y   <= op == ALU_DIV ? opr_n : acc_n;
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctrl = ALU_ADD;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y;
    logic        err;
    int          pass = 0;
    int          total = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err)
    );

    // issue one request from IDLE; lat = edges after the accept edge until out_valid is seen
    task automatic run_op(input logic [3:0] c, input logic [15:0] aa, input logic [15:0] bb,
                          output logic [15:0] ry, output logic re, output int lat);
        total++;
        if (in_ready !== 1'b1) $display("FAIL issue_ready ctrl=%h got in_ready=%b want 1", c, in_ready);
        else pass++;
        in_valid = 1'b1;
        ctrl = c;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctrl = ALU_ADD;
        a = 16'hDEAD;
        b = 16'h0000;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ry = y;
        re = err;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
        if (y !== 16'h0000) $display("FAIL reset_y got %h want 0000", y); else pass++;
        if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [15:0] ry;
        logic        re;
        int          lat;
        run_op(ALU_MUL, 16'h0003, 16'h0004, ry, re, lat);
        total += 3;
        if (ry !== 16'h000C) $display("FAIL mul_3x4_y got %h want 000C", ry); else pass++;
        if (re !== 1'b0) $display("FAIL mul_3x4_err got %b want 0", re); else pass++;
        if (lat != 16) $display("FAIL mul_3x4_latency got %0d want 16", lat); else pass++;
        consume();
        run_op(ALU_MUL, 16'h0100, 16'h0100, ry, re, lat);
        total += 2;
        if (ry !== 16'h0000) $display("FAIL mul_trunc_y got %h want 0000", ry); else pass++;
        if (re !== 1'b0) $display("FAIL mul_trunc_err got %b want 0", re); else pass++;
        consume();
        run_op(ALU_MUL, 16'hFFFF, 16'hFFFF, ry, re, lat);
        total++;
        if (ry !== 16'h0001) $display("FAIL mul_max_y got %h want 0001", ry); else pass++;
        consume();
    endtask

    task automatic test_div();
        logic [15:0] ry;
        logic        re;
        int          lat;
        run_op(ALU_DIV, 16'hFFFF, 16'h0010, ry, re, lat);
        total += 3;
        if (ry !== 16'h0FFF) $display("FAIL div_y got %h want 0FFF", ry); else pass++;
        if (re !== 1'b0) $display("FAIL div_err got %b want 0", re); else pass++;
        if (lat != 16) $display("FAIL div_latency got %0d want 16", lat); else pass++;
        consume();
        run_op(ALU_MOD, 16'hFFFF, 16'h0010, ry, re, lat);
        total += 2;
        if (ry !== 16'h000F) $display("FAIL mod_y got %h want 000F", ry); else pass++;
        if (re !== 1'b0) $display("FAIL mod_err got %b want 0", re); else pass++;
        consume();
    endtask

    task automatic test_div_zero();
        logic [15:0] ry;
        logic        re;
        int          lat;
        run_op(ALU_DIV, 16'h1234, 16'h0000, ry, re, lat);
        total += 3;
        if (ry !== 16'hFFFF) $display("FAIL div0_y got %h want FFFF", ry); else pass++;
        if (re !== 1'b1) $display("FAIL div0_err got %b want 1", re); else pass++;
        if (lat != 0) $display("FAIL div0_latency got %0d want 0", lat); else pass++;
        consume();
        run_op(ALU_MOD, 16'h1234, 16'h0000, ry, re, lat);
        total += 3;
        if (ry !== 16'h1234) $display("FAIL mod0_y got %h want 1234", ry); else pass++;
        if (re !== 1'b1) $display("FAIL mod0_err got %b want 1", re); else pass++;
        if (lat != 0) $display("FAIL mod0_latency got %0d want 0", lat); else pass++;
        consume();
    endtask

    task automatic test_unsupported();
        logic [15:0] ry;
        logic        re;
        int          lat;
        run_op(ALU_ADD, 16'h00F0, 16'h000F, ry, re, lat);
        total += 3;
        if (ry !== 16'h0000) $display("FAIL add_y got %h want 0000", ry); else pass++;
        if (re !== 1'b1) $display("FAIL add_err got %b want 1", re); else pass++;
        if (lat != 0) $display("FAIL add_latency got %0d want 0", lat); else pass++;
        consume();
    endtask

    task automatic test_hold();
        logic [15:0] ry;
        logic        re;
        int          lat;
        run_op(ALU_MUL, 16'h0003, 16'h0005, ry, re, lat);
        total++;
        if (ry !== 16'h000F) $display("FAIL hold_first_y got %h want 000F", ry); else pass++;
        ctrl = ALU_DIV;
        a = 16'h4321;
        b = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            @(posedge clk);
            #1;
            total += 4;
            if (out_valid !== 1'b1) $display("FAIL hold_valid cyc=%0d got %b want 1", i, out_valid); else pass++;
            if (y !== 16'h000F) $display("FAIL hold_y cyc=%0d got %h want 000F", i, y); else pass++;
            if (err !== 1'b0) $display("FAIL hold_err cyc=%0d got %b want 0", i, err); else pass++;
            if (in_ready !== 1'b0) $display("FAIL hold_in_ready cyc=%0d got %b want 0", i, in_ready); else pass++;
        end
        in_valid = 1'b1;
        a = 16'h0064;
        b = 16'h0007;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total += 2;
        if (in_ready !== 1'b1) $display("FAIL hs_in_ready got %b want 1", in_ready); else pass++;
        if (out_valid !== 1'b0) $display("FAIL hs_out_valid got %b want 0", out_valid); else pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) $display("FAIL next_accept_in_ready got %b want 0", in_ready); else pass++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total += 3;
        if (y !== 16'h000E) $display("FAIL next_div_y got %h want 000E", y); else pass++;
        if (err !== 1'b0) $display("FAIL next_div_err got %b want 0", err); else pass++;
        if (lat != 16) $display("FAIL next_div_latency got %0d want 16", lat); else pass++;
        consume();
    endtask

    task automatic test_reset_busy();
        logic [15:0] ry;
        logic        re;
        int          lat;
        int          seen;
        in_valid = 1'b1;
        ctrl = ALU_MUL;
        a = 16'h00FF;
        b = 16'h00FF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total += 4;
        if (in_ready !== 1'b1) $display("FAIL rst_busy_in_ready got %b want 1", in_ready); else pass++;
        if (out_valid !== 1'b0) $display("FAIL rst_busy_out_valid got %b want 0", out_valid); else pass++;
        if (y !== 16'h0000) $display("FAIL rst_busy_y got %h want 0000", y); else pass++;
        if (err !== 1'b0) $display("FAIL rst_busy_err got %b want 0", err); else pass++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL rst_busy_no_result got %0d valid cycles want 0", seen); else pass++;
        run_op(ALU_MUL, 16'h0002, 16'h0005, ry, re, lat);
        total += 3;
        if (ry !== 16'h000A) $display("FAIL after_rst_y got %h want 000A", ry); else pass++;
        if (re !== 1'b0) $display("FAIL after_rst_err got %b want 0", re); else pass++;
        if (lat != 16) $display("FAIL after_rst_latency got %0d want 16", lat); else pass++;
        consume();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{ALU_MUL, ALU_MUL, ALU_DIV, ALU_MOD};
        logic [15:0] va [4] = '{16'h0007, 16'h1234, 16'h00C8, 16'h03E8};
        logic [15:0] vb [4] = '{16'h0009, 16'h0010, 16'h000A, 16'h0007};
        logic [15:0] vy [4] = '{16'h003F, 16'h2340, 16'h0014, 16'h0006};
        logic [15:0] ry;
        logic        re;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], ry, re, lat);
            total += 2;
            if (ry !== vy[i]) $display("FAIL b2b_y idx=%0d got %h want %h", i, ry, vy[i]); else pass++;
            if (re !== 1'b0) $display("FAIL b2b_err idx=%0d got %b want 0", i, re); else pass++;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_unsupported();
        test_hold();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
